// File: rtl/ack_bus_pkg.sv
// Shared ACK bus definitions: source IDs, scheduler states, grant helpers.
// Used by the scheduler and by the existing ACK bus arbiter.
package ack_bus_pkg;

    localparam int NUM_ACK_SRC = 4;

    localparam logic [1:0] ID_MEM  = 2'd0;
    localparam logic [1:0] ID_SHA  = 2'd1;
    localparam logic [1:0] ID_AES  = 2'd2;
    localparam logic [1:0] ID_CTRL = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic logic [NUM_ACK_SRC-1:0] id_to_onehot(
        input logic [1:0] id
    );
        return NUM_ACK_SRC'(1) << id;
    endfunction

endpackage

// File: rtl/ack_rr_pick.sv
// Rotating priority encoder: first requester at or after ptr_i, wrapping.
// Fixed priority is the same encoder with ptr_i tied to MEM.
module ack_rr_pick
    import ack_bus_pkg::*;
(
    input  logic [NUM_ACK_SRC-1:0] req_i,
    input  logic [1:0]             ptr_i,
    output logic                   found_o,
    output logic [1:0]             id_o
);

    logic [2*NUM_ACK_SRC-1:0] dbl;
    logic [NUM_ACK_SRC-1:0]   rot;
    logic [1:0]               off;

    // Rotating the doubled vector puts ptr_i's source at bit 0.
    assign dbl = {req_i, req_i} >> ptr_i;
    assign rot = dbl[NUM_ACK_SRC-1:0];

    always_comb begin
        off = 2'd3;
        if (rot[0]) begin
            off = 2'd0;
        end else if (rot[1]) begin
            off = 2'd1;
        end else if (rot[2]) begin
            off = 2'd2;
        end
    end

    assign found_o = |rot;
    assign id_o    = ptr_i + off;

endmodule

// File: rtl/ack_bus_scheduler.sv
// Registered ACK bus scheduler: one-hot grant, held until done, request
// drop or timeout, followed by a one-cycle turnaround gap.
module ack_bus_scheduler
    import ack_bus_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter bit RR_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_mem,
    input  logic       req_sha,
    input  logic       req_aes,
    input  logic       req_ctrl,
    input  logic       ack_done,
    output logic       ack_ready_to_mem,
    output logic       ack_ready_to_sha,
    output logic       ack_ready_to_aes,
    output logic       ack_ready_to_ctrl,
    output logic [1:0] winner_source_id,
    output logic       ack_event,
    output logic       bus_busy,
    output logic       timeout_pulse
);

    localparam int CW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(HOLD_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

    state_t                 state_q, state_d;
    logic [NUM_ACK_SRC-1:0] grant_q, grant_d;
    logic [1:0]             win_q, win_d;
    logic [1:0]             ptr_q, ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   evt_q, evt_d;
    logic                   busy_q, busy_d;
    logic                   tmo_q, tmo_d;

    logic [NUM_ACK_SRC-1:0] req_vec;
    logic                   found;
    logic [1:0]             pick_id;
    logic                   win_req;
    logic                   hit_tmo;
    logic                   rel;

    assign req_vec = {req_ctrl, req_aes, req_sha, req_mem};

    ack_rr_pick u_pick (
        .req_i   (req_vec),
        .ptr_i   (RR_EN ? ptr_q : ID_MEM),
        .found_o (found),
        .id_o    (pick_id)
    );

    assign win_req = req_vec[win_q];
    assign hit_tmo = (HOLD_MAX != 0) && (cnt_q == CNT_LAST);
    assign rel     = ack_done || !win_req || hit_tmo;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            win_q   <= ID_MEM;
            ptr_q   <= ID_MEM;
            cnt_q   <= '0;
            evt_q   <= 1'b0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (found) state_d = BUSY;
            BUSY:    if (rel) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d = '0;
        win_d   = win_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        evt_d   = 1'b0;
        busy_d  = 1'b0;
        tmo_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = id_to_onehot(pick_id);
                    win_d   = pick_id;
                    cnt_d   = '0;
                    evt_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            BUSY: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                if (rel) begin
                    // Pulse only when the hold limit is the sole cause.
                    tmo_d = hit_tmo && !ack_done && win_req;
                    if (RR_EN) ptr_d = win_q + 2'd1;
                end else begin
                    grant_d = grant_q;
                    busy_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign ack_ready_to_mem  = grant_q[ID_MEM];
    assign ack_ready_to_sha  = grant_q[ID_SHA];
    assign ack_ready_to_aes  = grant_q[ID_AES];
    assign ack_ready_to_ctrl = grant_q[ID_CTRL];
    assign winner_source_id  = win_q;
    assign ack_event         = evt_q;
    assign bus_busy          = busy_q;
    assign timeout_pulse     = tmo_q;

    a_grant_onehot0 : assert property (
        @(posedge clk) $onehot0(grant_q)
    );

endmodule

// File: tb/tb_ack_bus_scheduler.sv
// Bench: round-robin and fixed-priority schedulers on shared inputs,
// directed scenarios plus random traffic against a behavioural model.
module tb_ack_bus_scheduler;

    localparam int HOLD = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, req_mem, req_sha, req_aes, req_ctrl, ack_done;

    logic rr_mem, rr_sha, rr_aes, rr_ctrl, rr_evt, rr_busy, rr_tmo;
    logic fx_mem, fx_sha, fx_aes, fx_ctrl, fx_evt, fx_busy, fx_tmo;
    logic [1:0] rr_id, fx_id;
    logic [3:0] rr_g, fx_g;

    assign rr_g = {rr_ctrl, rr_aes, rr_sha, rr_mem};
    assign fx_g = {fx_ctrl, fx_aes, fx_sha, fx_mem};

    ack_bus_scheduler #(.HOLD_MAX(HOLD), .RR_EN(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req_mem(req_mem), .req_sha(req_sha),
        .req_aes(req_aes), .req_ctrl(req_ctrl),
        .ack_done(ack_done),
        .ack_ready_to_mem(rr_mem), .ack_ready_to_sha(rr_sha),
        .ack_ready_to_aes(rr_aes), .ack_ready_to_ctrl(rr_ctrl),
        .winner_source_id(rr_id), .ack_event(rr_evt),
        .bus_busy(rr_busy), .timeout_pulse(rr_tmo)
    );

    ack_bus_scheduler #(.HOLD_MAX(HOLD), .RR_EN(1'b0)) dut_fx (
        .clk(clk), .rst_n(rst_n),
        .req_mem(req_mem), .req_sha(req_sha),
        .req_aes(req_aes), .req_ctrl(req_ctrl),
        .ack_done(ack_done),
        .ack_ready_to_mem(fx_mem), .ack_ready_to_sha(fx_sha),
        .ack_ready_to_aes(fx_aes), .ack_ready_to_ctrl(fx_ctrl),
        .winner_source_id(fx_id), .ack_event(fx_evt),
        .bus_busy(fx_busy), .timeout_pulse(fx_tmo)
    );

    // Model: holder = granted source or -1, age = grant cycles so far,
    // cool = turnaround cycles still owed before requests are looked at.
    int m_hold[2], m_age[2], m_cool[2], m_ptr[2], m_last[2];
    bit m_evt[2], m_tmo[2];

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d @%0t",
                      name, act, exp, $time);
    endtask

    task automatic model_step(input int m);
        logic [3:0] r;
        int s, w;
        bit hit;
        r = {req_ctrl, req_aes, req_sha, req_mem};
        m_evt[m] = 1'b0;
        m_tmo[m] = 1'b0;
        if (!rst_n) begin
            m_hold[m] = -1; m_age[m] = 0; m_cool[m] = 0;
            m_ptr[m] = 0; m_last[m] = 0;
        end else if (m_hold[m] >= 0) begin
            if (ack_done || !r[m_hold[m]] || m_age[m] == HOLD) begin
                m_tmo[m] = (m_age[m] == HOLD) && !ack_done && r[m_hold[m]];
                if (m == 0) m_ptr[m] = (m_hold[m] + 1) % 4;
                m_hold[m] = -1;
                m_cool[m] = 1;
            end else begin
                m_age[m]++;
            end
        end else if (m_cool[m] > 0) begin
            m_cool[m]--;
        end else if (r != 4'b0) begin
            s = (m == 0) ? m_ptr[m] : 0;
            w = 0;
            hit = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (!hit && r[(s + k) % 4]) begin
                    w = (s + k) % 4;
                    hit = 1'b1;
                end
            end
            m_hold[m] = w; m_age[m] = 1; m_evt[m] = 1'b1; m_last[m] = w;
        end
    endtask

    task automatic cmp(input int m, input string p, input int g,
                       input int id, input int ev, input int bz,
                       input int to);
        int eg;
        eg = (m_hold[m] >= 0) ? (1 << m_hold[m]) : 0;
        chk({p, " grant"}, g, eg);
        chk({p, " id"}, id, m_last[m]);
        chk({p, " ack_event"}, ev, int'(m_evt[m]));
        chk({p, " bus_busy"}, bz, int'(m_hold[m] >= 0));
        chk({p, " timeout"}, to, int'(m_tmo[m]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        cmp(0, "rr", rr_g, rr_id, rr_evt, rr_busy, rr_tmo);
        cmp(1, "fx", fx_g, fx_id, fx_evt, fx_busy, fx_tmo);
    endtask

    task automatic set_reqs(input logic [3:0] v);
        {req_ctrl, req_aes, req_sha, req_mem} = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_reqs(4'b0);
        ack_done = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};
    int since, gapc, nev, cnt, mode;
    bit saw_tmo;

    initial begin
        rst_n = 1'b0;
        set_reqs(4'b0);
        ack_done = 1'b0;
        tick();
        tick();
        chk("reset grant", rr_g, 0);
        chk("reset id", rr_id, 0);
        chk("reset busy", rr_busy, 0);
        rst_n = 1'b1;
        tick();

        // Single AES request
        req_aes = 1'b1;
        tick();
        chk("aes grant", rr_g, 4'b0100);
        chk("aes id", rr_id, 2);
        chk("aes event", rr_evt, 1);
        chk("aes busy", rr_busy, 1);
        tick();
        chk("aes event once", rr_evt, 0);
        ack_done = 1'b1;
        tick();
        ack_done = 1'b0;
        req_aes = 1'b0;
        chk("aes released", rr_g, 0);
        chk("aes gap busy", rr_busy, 0);
        tick();
        tick();

        // Round-robin fairness, fixed mode stays on MEM
        do_reset();
        set_reqs(4'b1111);
        since = -1; gapc = 0; nev = 0;
        for (int c = 0; c < 80 && nev < 5; c++) begin
            ack_done = rr_busy && (since == 2);
            tick();
            if (rr_evt) begin
                chk("rr order", rr_id, exp_order[nev]);
                chk("fx stays mem", fx_g, 4'b0001);
                if (nev > 0) chk("rr gap cycles", gapc, 2);
                nev++; since = 0; gapc = 0;
            end else if (rr_g != 4'b0) begin
                since++;
            end else begin
                gapc++;
            end
        end
        chk("rr grant count", nev, 5);
        ack_done = 1'b0;

        // Timeout on SHA, pointer moves to AES
        do_reset();
        req_sha = 1'b1;
        cnt = 0; saw_tmo = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (rr_sha) begin
                cnt++;
            end else if (cnt > 0) begin
                saw_tmo = rr_tmo;
                break;
            end
        end
        chk("timeout hold cycles", cnt, 15);
        chk("timeout pulse", int'(saw_tmo), 1);
        set_reqs(4'b1111);
        tick();
        chk("post timeout idle", rr_g, 0);
        tick();
        chk("rr after timeout", rr_id, 2);
        chk("fx after timeout", fx_id, 0);
        ack_done = 1'b1;
        tick();
        ack_done = 1'b0;
        set_reqs(4'b0);
        tick();

        // ack_done coinciding with the hold limit
        do_reset();
        req_mem = 1'b1;
        tick();
        repeat (14) tick();
        chk("mem held 15th cycle", rr_g, 4'b0001);
        ack_done = 1'b1;
        tick();
        ack_done = 1'b0;
        req_mem = 1'b0;
        chk("coincident no pulse", rr_tmo, 0);
        chk("coincident released", rr_g, 0);
        tick();
        tick();

        // Request drop together with ack_done
        req_mem = 1'b1;
        tick();
        tick();
        req_mem = 1'b0;
        ack_done = 1'b1;
        tick();
        ack_done = 1'b0;
        chk("drop+done released", rr_g, 0);
        tick();
        tick();
        chk("drop+done stays idle", rr_busy, 0);

        // Reset in the middle of a CTRL grant
        do_reset();
        req_ctrl = 1'b1;
        tick();
        chk("ctrl granted", rr_g, 4'b1000);
        tick();
        rst_n = 1'b0;
        tick();
        chk("mid reset grant", rr_g, 0);
        chk("mid reset id", rr_id, 0);
        chk("mid reset busy", rr_busy, 0);
        rst_n = 1'b1;
        set_reqs(4'b1111);
        tick();
        chk("post reset mem", rr_g, 4'b0001);
        chk("post reset id", rr_id, 0);

        // Random traffic: alternating busy and quiet epochs
        for (int c = 0; c < 4000; c++) begin
            mode = (c / 250) % 2;
            rst_n = ($urandom_range(0, 399) != 0);
            if (mode == 0) begin
                if ($urandom_range(0, 3) == 0) req_mem  = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) req_sha  = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) req_aes  = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) req_ctrl = 1'($urandom_range(0, 1));
                ack_done = ($urandom_range(0, 7) == 0);
            end else begin
                if ($urandom_range(0, 39) == 0) req_mem  = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 39) == 0) req_sha  = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 39) == 0) req_aes  = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 39) == 0) req_ctrl = 1'($urandom_range(0, 1));
                ack_done = ($urandom_range(0, 63) == 0);
            end
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
